// File: rtl/mole_round_ctrl.sv
// mole_round_ctrl: whack-a-mole sequencer (pick, show, score, gap, repeat).
// Define MOLE_RAMP_EN to shorten the on-time each round down to ON_MIN.
module mole_round_ctrl #(
   parameter int ROUNDS   = 10,
   parameter int ON_TIME  = 25000000,
   parameter int OFF_TIME = 5000000,
   parameter int TW       = 26
`ifdef MOLE_RAMP_EN
   ,
   parameter int RAMP_STEP = 1000000,
   parameter int ON_MIN    = 5000000
`endif
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [4:0]  rnd,
   input  logic [17:0] hit,
   output logic [17:0] displayL,
   output logic [7:0]  score,
   output logic [7:0]  misses,
   output logic [7:0]  round_num,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {
      IDLE,
      PICK,
      SHOW,
      GAP,
      DONE
   } state_t;

   localparam logic [TW-1:0] ON_LD    = TW'(ON_TIME);
   localparam logic [TW-1:0] OFF_LD   = TW'(OFF_TIME - 1);
   localparam logic [7:0]    ROUNDS_C = 8'(ROUNDS);

   state_t        state;
   logic [4:0]    prev_idx;
   logic [17:0]   hit_q;
   logic [TW-1:0] timer;
   logic [TW-1:0] on_reload;
   logic [TW-1:0] next_reload;
   logic [4:0]    raw_idx;
   logic [4:0]    pick_idx;
   logic [17:0]   hit_rise;
   logic          good_hit;
   logic          bad_hit;
   logic [7:0]    round_inc;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Fold rnd onto 18 moles and bump past the previous mole to avoid repeats
   always_comb begin
      raw_idx  = (rnd < 5'd18) ? rnd : rnd - 5'd18;
      pick_idx = raw_idx;
      if (raw_idx == prev_idx)
         pick_idx = (raw_idx == 5'd17) ? 5'd0 : raw_idx + 5'd1;
   end

   assign hit_rise  = hit & ~hit_q;
   assign good_hit  = |(hit_rise & displayL);
   assign bad_hit   = |(hit_rise & ~displayL);
   assign round_inc = round_num + 8'd1;

`ifdef MOLE_RAMP_EN
   localparam logic [TW-1:0] STEP_T = TW'(RAMP_STEP);
   localparam logic [TW-1:0] MIN_T  = TW'(ON_MIN);

   // Shrink the on-time after each round, saturating at the floor
   always_comb begin
      if (int'(on_reload) >= ON_MIN + RAMP_STEP)
         next_reload = on_reload - STEP_T;
      else
         next_reload = MIN_T;
   end
`else
   assign next_reload = on_reload;
`endif

   // Round sequencer; every output is a registered decode of this FSM
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         displayL  <= '0;
         score     <= '0;
         misses    <= '0;
         round_num <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         prev_idx  <= 5'd31;
         hit_q     <= '0;
         timer     <= '0;
         on_reload <= '0;
      end else begin
         hit_q <= hit;
         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  score     <= '0;
                  misses    <= '0;
                  round_num <= '0;
                  on_reload <= ON_LD;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  state     <= PICK;
               end
            end
            PICK: begin
               displayL <= 18'd1 << pick_idx;
               prev_idx <= pick_idx;
               timer    <= on_reload - TW'(1);
               state    <= SHOW;
            end
            SHOW: begin
               if (good_hit) begin
                  score    <= sat_inc(score);
                  displayL <= '0;
                  timer    <= OFF_LD;
                  state    <= GAP;
               end else if (bad_hit) begin
                  misses <= sat_inc(misses);
               end else if (timer == '0) begin
                  misses   <= sat_inc(misses);
                  displayL <= '0;
                  timer    <= OFF_LD;
                  state    <= GAP;
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            GAP: begin
               if (timer == '0) begin
                  round_num <= round_inc;
                  on_reload <= next_reload;
                  if (round_inc == ROUNDS_C) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     state <= PICK;
                  end
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            default: begin
               busy     <= 1'b0;
               done     <= 1'b0;
               displayL <= '0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule
